// File: rtl/ipsxe_floating_point_result_axis_rx_v1_0_if.sv
// AXI4-Stream result channel carrying a float result plus {overflow, underflow} in tuser.
interface ipsxe_floating_point_result_axis_rx_v1_0_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [1:0]            tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/ipsxe_floating_point_result_axis_rx_v1_0.sv
// Result buffer between a ready-less float core and an AXI4-Stream consumer.
// Backpressure is applied by withholding the core clock enable when the buffer is full.
module ipsxe_floating_point_result_axis_rx_v1_0 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_aclken,
    output logic                        o_core_aclken,
    input  logic [DATA_WIDTH-1:0]       i_result_float,
    input  logic                        i_result_valid,
    input  logic                        i_overflow,
    input  logic                        i_underflow,
    ipsxe_floating_point_result_axis_rx_v1_0_if.master m_axis,
    output logic [$clog2(DEPTH):0]      o_level,
    output logic                        o_ovf_seen,
    output logic                        o_unf_seen,
    input  logic                        i_clr_flags
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 2;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic          ovf_seen;
    logic          ovf_nxt;
    logic          unf_seen;
    logic          unf_nxt;

    logic          not_empty_c;
    logic          not_full_c;
    logic          pop_c;
    logic          push_c;
    logic          core_en_c;
    logic [EW-1:0] head_c;

    // Handshake decode; reset forces the enable to follow i_aclken as if empty.
    always_comb begin
        not_empty_c = (level != LW'(0));
        not_full_c  = (level < LW'(DEPTH));
        pop_c       = not_empty_c && m_axis.tready;
        core_en_c   = i_aclken && (i_rst || not_full_c || pop_c);
        push_c      = i_result_valid && core_en_c;
        head_c      = mem[rd_ptr];
    end

    // Next-state for pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        ovf_nxt    = ovf_seen;
        unf_nxt    = unf_seen;

        if (push_c) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end

        if (push_c && !pop_c) begin
            level_nxt = level + LW'(1);
        end else if (pop_c && !push_c) begin
            level_nxt = level - LW'(1);
        end

        // Clear first so a same-cycle set takes priority.
        if (i_clr_flags) begin
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
        end
        if (push_c && i_overflow) begin
            ovf_nxt = 1'b1;
        end
        if (push_c && i_underflow) begin
            unf_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_seen <= 1'b0;
            unf_seen <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            ovf_seen <= ovf_nxt;
            unf_seen <= unf_nxt;
        end
    end

    // Storage is left uninitialised; only occupancy decides what is visible.
    always_ff @(posedge i_clk) begin
        if (push_c && !i_rst) begin
            mem[wr_ptr] <= {i_overflow, i_underflow, i_result_float};
        end
    end

    assign o_core_aclken = core_en_c;
    assign o_level       = level;
    assign o_ovf_seen    = ovf_seen;
    assign o_unf_seen    = unf_seen;
    assign m_axis.tvalid = not_empty_c;
    assign m_axis.tdata  = head_c[DATA_WIDTH-1:0];
    assign m_axis.tuser  = head_c[EW-1:EW-2];

endmodule

// File: tb/tb_ipsxe_floating_point_result_axis_rx_v1_0.sv
// Scoreboard bench: the core model queues each distinct result once; a monitor checks every pop.
module tb_ipsxe_floating_point_result_axis_rx_v1_0;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          aclken;
    logic          core_aclken;
    logic [DW-1:0] result_float;
    logic          result_valid;
    logic          overflow;
    logic          underflow;
    logic [3:0]    level;
    logic          ovf_seen;
    logic          unf_seen;
    logic          clr_flags;

    int total;
    int bad;

    logic [DW+1:0] exp_q[$];

    ipsxe_floating_point_result_axis_rx_v1_0_if #(.DATA_WIDTH(DW)) axis ();

    ipsxe_floating_point_result_axis_rx_v1_0 #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_aclken      (aclken),
        .o_core_aclken (core_aclken),
        .i_result_float(result_float),
        .i_result_valid(result_valid),
        .i_overflow    (overflow),
        .i_underflow   (underflow),
        .m_axis        (axis),
        .o_level       (level),
        .o_ovf_seen    (ovf_seen),
        .o_unf_seen    (unf_seen),
        .i_clr_flags   (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core model: result held until the core enable lets it through.
    task automatic send(input logic [DW-1:0] d, input logic ovf, input logic unf);
        logic acc;
        int   n;
        exp_q.push_back({ovf, unf, d});
        result_float = d;
        overflow     = ovf;
        underflow    = unf;
        result_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = core_aclken;
            @(posedge clk);
            #1;
            n++;
        end
        result_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no acceptance expected acceptance of %h", d);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        step();
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_level0"}, 64'(level), 64'd0);
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid&&ready is seen here.
    always @(negedge clk) begin
        logic [DW+1:0] e;
        if (!rst && axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h expected no beat", {axis.tuser, axis.tdata});
            end else begin
                e = exp_q.pop_front();
                chk("beat", 64'({axis.tuser, axis.tdata}), 64'(e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] fill_vals [10];
    logic [15:0]   rdy_pat;

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        aclken       = 1'b1;
        result_float = '0;
        result_valid = 1'b0;
        overflow     = 1'b0;
        underflow    = 1'b0;
        clr_flags    = 1'b0;
        axis.tready  = 1'b0;
        fill_vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                      32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        rdy_pat   = 16'b1011_0010_1110_0101;

        repeat (2) step();
        chk("rst_core_aclken", 64'(core_aclken), 64'd1);
        rst = 1'b0;
        step();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_flags", 64'({ovf_seen, unf_seen}), 64'd0);

        // Single push with ready high: visible for exactly one cycle.
        axis.tready = 1'b1;
        send(32'h3F800000, 1'b0, 1'b0);
        chk("single_tvalid", 64'(axis.tvalid), 64'd1);
        chk("single_level", 64'(level), 64'd1);
        step();
        chk("single_tvalid_gone", 64'(axis.tvalid), 64'd0);

        // Status bits and sticky flags, including clear colliding with a set.
        axis.tready = 1'b0;
        send(32'h7F800000, 1'b1, 1'b0);
        chk("ovf_tuser", 64'(axis.tuser), 64'd2);
        chk("ovf_tdata", 64'(axis.tdata), 64'h7F800000);
        chk("ovf_seen", 64'(ovf_seen), 64'd1);
        clr_flags = 1'b1;
        send(32'h00000000, 1'b0, 1'b1);
        clr_flags = 1'b0;
        chk("unf_set_wins", 64'(unf_seen), 64'd1);
        chk("ovf_cleared", 64'(ovf_seen), 64'd0);
        chk("head_stable", 64'(axis.tdata), 64'h7F800000);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("unf_cleared", 64'(unf_seen), 64'd0);
        axis.tready = 1'b1;
        drain("status");

        // Fill past capacity with ready low, then release.
        axis.tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(fill_vals[i], 1'b0, 1'b0);
            end
            begin
                repeat (12) step();
                chk("full_level", 64'(level), 64'd8);
                chk("full_aclken", 64'(core_aclken), 64'd0);
                axis.tready = 1'b1;
                step();
                chk("full_flow_level", 64'(level), 64'd8);
                chk("full_flow_aclken", 64'(core_aclken), 64'd1);
            end
        join
        drain("fill");

        // Streaming across pointer wrap with a ready pattern.
        fork
            begin
                for (int i = 0; i < 12; i++) send(32'hA5000000 | DW'(i * 32'h00010203), 1'(i % 3 == 0), 1'(i % 4 == 1));
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    axis.tready = rdy_pat[i];
                    step();
                end
                axis.tready = 1'b1;
            end
        join
        drain("stream");
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;

        // Reset with five entries buffered.
        axis.tready = 1'b0;
        send(32'h11111111, 1'b0, 1'b0);
        send(32'h22222222, 1'b1, 1'b0);
        send(32'h33333333, 1'b0, 1'b1);
        send(32'h44444444, 1'b0, 1'b0);
        send(32'h55555555, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd5);
        chk("pre_rst_flags", 64'({ovf_seen, unf_seen}), 64'd3);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("mid_rst_flags", 64'({ovf_seen, unf_seen}), 64'd0);
        axis.tready = 1'b1;
        send(32'h40490FDB, 1'b0, 1'b0);
        drain("post_rst");

        // Upstream enable low: core frozen, buffer still drains.
        axis.tready = 1'b0;
        send(32'hC0000000, 1'b0, 1'b0);
        send(32'hC0400000, 1'b0, 1'b0);
        send(32'hC0800000, 1'b0, 1'b0);
        chk("aclken_level3", 64'(level), 64'd3);
        aclken       = 1'b0;
        result_float = 32'hDEADBEEF;
        result_valid = 1'b1;
        axis.tready  = 1'b1;
        #1;
        chk("aclken_low_core", 64'(core_aclken), 64'd0);
        drain("aclken_low");
        step();
        chk("aclken_no_push", 64'(level), 64'd0);
        result_valid = 1'b0;
        aclken       = 1'b1;
        repeat (2) step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("final_tvalid", 64'(axis.tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
